// File: rtl/pio_ctrl.sv
// pio_ctrl: loads a PIO block with program words and configuration entries,
// then arbitrates four push requesters round-robin onto the PIO command bus.
// Optional feature macro: PIO_CTRL_STALL_CNT_EN (enables the stall counter;
// when undefined stall_cnt is tied to zero).
module pio_ctrl #(
    parameter int PROG_LEN = 32,
    parameter int CONF_LEN = 5
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    output logic [4:0]   prog_addr,
    input  logic [15:0]  prog_data,
    output logic [4:0]   conf_addr,
    input  logic [37:0]  conf_data,
    input  logic [3:0]   req,
    input  logic [127:0] req_data,
    output logic [3:0]   grant,
    input  logic [3:0]   tx_full,
    output logic [5:0]   action,
    output logic [4:0]   index,
    output logic [1:0]   mindex,
    output logic [31:0]  din,
    output logic         ready,
    output logic [7:0]   stall_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, CONF, RUN} state_t;

    localparam logic [5:0] ACT_NOP   = 6'd0;
    localparam logic [5:0] ACT_LOAD  = 6'd1;
    localparam logic [5:0] ACT_PUSH  = 6'd4;
    localparam logic [4:0] PROG_LAST = 5'(PROG_LEN - 1);
    localparam logic [4:0] CONF_LAST = 5'(CONF_LEN - 1);
    localparam bit         NO_CONF   = (CONF_LEN == 0);

    state_t        state_q;
    logic [4:0]    prog_addr_q;
    logic [4:0]    conf_addr_q;
    logic [5:0]    action_q;
    logic [4:0]    index_q;
    logic [1:0]    mindex_q;
    logic [31:0]   din_q;
    logic [3:0]    grant_q;
    logic          ready_q;
    logic [1:0]    rr_q;    // first machine examined by the next arbitration
    logic          gap_q;   // forces one quiet cycle after a push or after CONF

    logic [3:0]    elig;
    logic          win_valid;
    logic [1:0]    win_idx;
    logic [1:0]    cand;
    logic [31:0]   win_data;
    logic          start_ok;
    logic          load_now;

    // Round-robin pick among eligible machines, starting at rr_q.
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        elig      = req & ~tx_full;
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        win_data = req_data[{win_idx, 5'd0} +: 32];
        start_ok = start && (state_q == IDLE || state_q == RUN);
        // A word is emitted on the start edge itself and on every LOAD edge.
        load_now = (state_q == LOAD) || start_ok;
    end

    // Sequencer: state, addresses and the registered PIO command bus.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            prog_addr_q <= 5'd0;
            conf_addr_q <= 5'd0;
            action_q    <= ACT_NOP;
            index_q     <= 5'd0;
            mindex_q    <= 2'd0;
            din_q       <= 32'd0;
            grant_q     <= 4'd0;
            ready_q     <= 1'b0;
            rr_q        <= 2'd0;
            gap_q       <= 1'b0;
        end else begin
            action_q <= ACT_NOP;
            index_q  <= 5'd0;
            mindex_q <= 2'd0;
            din_q    <= 32'd0;
            grant_q  <= 4'd0;

            if (load_now) begin
                action_q <= ACT_LOAD;
                index_q  <= prog_addr_q;
                din_q    <= {16'h0, prog_data};
                ready_q  <= 1'b0;
                gap_q    <= 1'b0;
                if (prog_addr_q == PROG_LAST) begin
                    prog_addr_q <= 5'd0;
                    if (NO_CONF) begin
                        state_q <= RUN;
                        gap_q   <= 1'b1;
                    end else begin
                        state_q <= CONF;
                    end
                end else begin
                    prog_addr_q <= prog_addr_q + 5'd1;
                    state_q     <= LOAD;
                end
            end else begin
                case (state_q)
                    CONF: begin
                        action_q <= {2'b00, conf_data[35:32]};
                        mindex_q <= conf_data[37:36];
                        din_q    <= conf_data[31:0];
                        if (conf_addr_q == CONF_LAST) begin
                            conf_addr_q <= 5'd0;
                            state_q     <= RUN;
                            gap_q       <= 1'b1;
                        end else begin
                            conf_addr_q <= conf_addr_q + 5'd1;
                        end
                    end
                    RUN: begin
                        if (gap_q) begin
                            gap_q <= 1'b0;
                        end else begin
                            ready_q <= 1'b1;
                            if (win_valid) begin
                                action_q <= ACT_PUSH;
                                mindex_q <= win_idx;
                                din_q    <= win_data;
                                grant_q  <= 4'b0001 << win_idx;
                                rr_q     <= win_idx + 2'd1;
                                gap_q    <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PIO_CTRL_STALL_CNT_EN
    logic [7:0] stall_q;

    // Saturating count of RUN cycles where a requester is blocked by a full FIFO.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stall_q <= 8'd0;
        end else if (start_ok) begin
            stall_q <= 8'd0;
        end else if (state_q == RUN && |(req & tx_full) && stall_q != 8'hFF) begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 8'd0;
`endif

    assign prog_addr = prog_addr_q;
    assign conf_addr = conf_addr_q;
    assign action    = action_q;
    assign index     = index_q;
    assign mindex    = mindex_q;
    assign din       = din_q;
    assign grant     = grant_q;
    assign ready     = ready_q;

endmodule

// File: doc/pio_ctrl.md
PIO_CTRL -- requirements
Module: pio_ctrl

Interface
REQ-001 Parameter PROG_LEN, default 32: number of program words loaded (1..32).
REQ-002 Parameter CONF_LEN, default 5: number of configuration entries applied (0..32).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 n_reset  input  1  asynchronous active-low reset.
REQ-005 start  input  1  pulse; begins a load and configure sequence from IDLE or RUN.
REQ-006 prog_addr  output  5  program memory address; prog_data is valid combinationally in the same cycle.
REQ-007 prog_data  input  16  PIO instruction word at prog_addr.
REQ-008 conf_addr  output  5  configuration memory address; conf_data is valid combinationally in the same cycle.
REQ-009 conf_data  input  38  configuration entry: [37:36] mindex, [35:32] action, [31:0] din.
REQ-010 req  input  4  per-machine push request, level-held until granted.
REQ-011 req_data  input  128  push data; machine i uses bits [32i+31:32i].
REQ-012 grant  output  4  one-hot, one-cycle pulse; req_data[i] was consumed.
REQ-013 tx_full  input  4  PIO TX FIFO full flags.
REQ-014 action, index, mindex, din  output  6, 5, 2, 32  PIO command bus; all registered.
REQ-015 ready  output  1  high only in RUN.
REQ-016 stall_cnt  output  8  stall statistic (see Configuration).

Function
REQ-017 State machine has four states: IDLE, LOAD, CONF, RUN. Reset state is IDLE.
REQ-018 start in IDLE or RUN -> LOAD next cycle. start in LOAD or CONF is ignored.
REQ-019 LOAD issues PROG_LEN consecutive cycles of action=1, index=k, din={16'h0,prog_data@k}, for k=0..PROG_LEN-1.
REQ-020 After the word PROG_LEN-1, LOAD -> CONF; CONF_LEN=0 goes straight to RUN.
REQ-021 CONF issues CONF_LEN consecutive cycles, one per entry k: mindex, action and din taken from conf_data@k; index=0.
REQ-022 After the last entry, CONF -> RUN with action=0.
REQ-023 In RUN, a machine i is eligible when req[i]=1 and tx_full[i]=0.
REQ-024 Among eligible machines, grant goes round-robin, starting at the machine after the last granted one; the pointer resets to machine 0.
REQ-025 A grant cycle drives action=4 (PUSH), mindex=i, din=req_data[i], and grant[i]=1, all in the same cycle.
REQ-026 Every PUSH cycle is followed by exactly one cycle with action=0 and grant=0, so the PIO sees tx_full updated before the next push; maximum rate is one push per 2 cycles.
REQ-027 req[i] with tx_full[i]=1 is never granted; other eligible machines proceed without blocking.
REQ-028 When no machine is eligible: action=0 and grant=0.
REQ-029 start arriving in a PUSH cycle completes that PUSH; LOAD begins the next cycle.
REQ-030 grant is never asserted outside RUN.

Reset
REQ-031 Assertion of n_reset immediately clears: state to IDLE; action, index, mindex, din, grant, prog_addr and conf_addr to 0; ready to 0; stall_cnt to 0; round-robin pointer to 0.
REQ-032 Reset mid-LOAD or mid-CONF abandons the sequence. After deassertion the block waits in IDLE for start.

Configuration
REQ-033 Macro PIO_CTRL_STALL_CNT_EN.
REQ-034 Defined: stall_cnt increments once per RUN cycle in which any (req[i] & tx_full[i]) is true. It saturates at 255 and clears on start.
REQ-035 Undefined: stall_cnt is constant 0 and no counter logic is present.

Verification
REQ-036 Reset release, start pulse, PROG_LEN=32 -> 32 cycles of action=1 with index 0..31 and din equal to memory words. Then 5 CONF cycles matching conf_data. Then ready=1 exactly 38 cycles after the start-sample edge (1 + 32 + 5).
REQ-037 RUN, req=4'b1111, tx_full=0 -> grants in order 0,1,2,3,0, each PUSH separated by one action=0 cycle.
REQ-038 RUN, req=4'b0101, tx_full=4'b0001 -> only machine 2 is granted, every 2 cycles; with the macro defined, stall_cnt increments every cycle.
REQ-039 n_reset low at LOAD index 10 -> all outputs 0 at once. After release, no activity until start; the next start reloads from index 0.
REQ-040 start asserted during a RUN grant cycle -> that PUSH completes; the next cycle is action=1, index=0.
